// File: rtl/game_pkg.sv
// Shared types and codes for the factorization-game round sequencer.
package game_pkg;

  localparam int unsigned DB_W    = 36;
  localparam int unsigned LVL_MSB = 35;
  localparam int unsigned LVL_LSB = 34;
  localparam int unsigned NUM_MSB = 33;
  localparam int unsigned LVL_W   = 2;
  localparam int unsigned NUM_W   = 34;
  localparam int unsigned EVT_W   = 3;
  localparam int unsigned RES_W   = 3;
  localparam int unsigned WIN_W   = 2;
  localparam int unsigned RCNT_W  = 8;

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_FETCH, ST_WAIT_DB, ST_ANSWER,
    ST_JUDGE, ST_SETTLE, ST_CHECK, ST_OVER
  } state_t;

  localparam logic [EVT_W-1:0] EVT_NONE = 3'b000;
  localparam logic [EVT_W-1:0] EVT_P1   = 3'b001;
  localparam logic [EVT_W-1:0] EVT_P2   = 3'b010;
  localparam logic [EVT_W-1:0] EVT_DRAW = 3'b011;

  localparam logic [RES_W-1:0] RES_NONE   = 3'b000;
  localparam logic [RES_W-1:0] RES_P1_WIN = 3'b001;
  localparam logic [RES_W-1:0] RES_P2_WIN = 3'b010;

  localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
  localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;

  typedef struct packed {
    logic [LVL_W-1:0] level;
    logic [NUM_W-1:0] num;
  } db_word_t;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Handshake bundle between the round sequencer (master) and DB / players / HP manager (slave).
interface game_round_ctrl_if #(parameter int unsigned ADDR_W = 6);
  import game_pkg::*;

  logic                start;
  logic                db_req;
  logic [ADDR_W-1:0]   db_addr;
  logic                db_valid;
  logic [DB_W-1:0]     db_data;
  logic                q_show;
  logic [LVL_W-1:0]    q_level;
  logic [NUM_W-1:0]    q_num;
  logic                p1_ans;
  logic                p1_ok;
  logic                p2_ans;
  logic                p2_ok;
  logic                hp_init;
  logic [EVT_W-1:0]    hp_evt;
  logic [RES_W-1:0]    hp_result;
  logic                game_over;
  logic [WIN_W-1:0]    winner;
  logic [RCNT_W-1:0]   round_cnt;

  modport master (
    input  start, db_valid, db_data, p1_ans, p1_ok, p2_ans, p2_ok, hp_result,
    output db_req, db_addr, q_show, q_level, q_num, hp_init, hp_evt,
           game_over, winner, round_cnt
  );

  modport slave (
    output start, db_valid, db_data, p1_ans, p1_ok, p2_ans, p2_ok, hp_result,
    input  db_req, db_addr, q_show, q_level, q_num, hp_init, hp_evt,
           game_over, winner, round_cnt
  );

endinterface

// File: rtl/game_round_ctrl_answer_arbiter.sv
// Per-round answer arbitration: lockout flags plus same-cycle resolution of the two players.
module answer_arbiter
  import game_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_p1_ans,
  input  logic             i_p1_ok,
  input  logic             i_p2_ans,
  input  logic             i_p2_ok,
  output logic             o_done_c,
  output logic [EVT_W-1:0] o_evt_c
);

  logic r_p1_lock, r_p2_lock;
  logic w_p1_win, w_p2_win, w_p1_lock_nxt, w_p2_lock_nxt;

  // A wrong answer in the same cycle as the other player's correct one still loses.
  always_comb begin
    w_p1_win      = i_en & i_p1_ans & i_p1_ok & ~r_p1_lock;
    w_p2_win      = i_en & i_p2_ans & i_p2_ok & ~r_p2_lock;
    w_p1_lock_nxt = r_p1_lock | (i_en & i_p1_ans & ~i_p1_ok);
    w_p2_lock_nxt = r_p2_lock | (i_en & i_p2_ans & ~i_p2_ok);
    o_done_c      = 1'b0;
    o_evt_c       = EVT_NONE;
    if (w_p1_win && w_p2_win) begin
      o_done_c = 1'b1;
      o_evt_c  = EVT_DRAW;
    end else if (w_p1_win) begin
      o_done_c = 1'b1;
      o_evt_c  = EVT_P1;
    end else if (w_p2_win) begin
      o_done_c = 1'b1;
      o_evt_c  = EVT_P2;
    end else if (i_en && w_p1_lock_nxt && w_p2_lock_nxt) begin
      o_done_c = 1'b1;
      o_evt_c  = EVT_DRAW;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p1_lock <= 1'b0;
      r_p2_lock <= 1'b0;
    end else if (i_clr) begin
      r_p1_lock <= 1'b0;
      r_p2_lock <= 1'b0;
    end else if (i_en) begin
      r_p1_lock <= w_p1_lock_nxt;
      r_p2_lock <= w_p2_lock_nxt;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the two-player factorization game.
// Optional answer-window timeout enabled by defining ROUND_TIMEOUT_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned NUM_Q   = 64,
  parameter int unsigned TMO_CYC = 5000,
  parameter int unsigned SETTLE  = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  game_round_ctrl_if.master io_bus
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (ADDR_W < 1 || NUM_Q < 2 || NUM_Q > (1 << ADDR_W) || SETTLE < 1 || TMO_CYC < 2) begin : g_bad_param
    $error("game_round_ctrl: illegal parameter combination");
  end

  state_t            r_state;
  logic              r_db_req;
  logic [ADDR_W-1:0] r_db_addr;
  db_word_t          r_q;
  logic              r_q_show;
  logic              r_hp_init;
  logic [EVT_W-1:0]  r_hp_evt;
  logic              r_game_over;
  logic [WIN_W-1:0]  r_winner;
  logic [RCNT_W-1:0] r_round_cnt;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              w_arb_done;
  logic [EVT_W-1:0]  w_arb_evt;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  answer_arbiter u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (r_state == ST_ANSWER),
    .i_clr    (r_state == ST_FETCH),
    .i_p1_ans (io_bus.p1_ans),
    .i_p1_ok  (io_bus.p1_ok),
    .i_p2_ans (io_bus.p2_ans),
    .i_p2_ok  (io_bus.p2_ok),
    .o_done_c (w_arb_done),
    .o_evt_c  (w_arb_evt)
  );

  // Main sequencer; pulse outputs default low every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_db_req     <= 1'b0;
      r_db_addr    <= '0;
      r_q          <= '0;
      r_q_show     <= 1'b0;
      r_hp_init    <= 1'b0;
      r_hp_evt     <= EVT_NONE;
      r_game_over  <= 1'b0;
      r_winner     <= WIN_NONE;
      r_round_cnt  <= '0;
      r_settle_cnt <= '0;
`ifdef ROUND_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_db_req  <= 1'b0;
      r_hp_init <= 1'b0;
      r_hp_evt  <= EVT_NONE;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (io_bus.start) begin
            r_state     <= ST_INIT;
            r_hp_init   <= 1'b1;
            r_round_cnt <= '0;
            r_winner    <= WIN_NONE;
            r_game_over <= 1'b0;
          end
        end
        ST_INIT: begin
          r_state  <= ST_FETCH;
          r_db_req <= 1'b1;
        end
        ST_FETCH: r_state <= ST_WAIT_DB;
        ST_WAIT_DB: begin
          if (io_bus.db_valid) begin
            r_q      <= '{level: io_bus.db_data[LVL_MSB:LVL_LSB], num: io_bus.db_data[NUM_MSB:0]};
            r_q_show <= 1'b1;
            r_state  <= ST_ANSWER;
`ifdef ROUND_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        ST_ANSWER: begin
          if (w_arb_done) begin
            r_hp_evt <= w_arb_evt;
            r_q_show <= 1'b0;
            r_state  <= ST_JUDGE;
          end
`ifdef ROUND_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            r_hp_evt <= EVT_DRAW;
            r_q_show <= 1'b0;
            r_state  <= ST_JUDGE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_JUDGE: begin
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SET_W'(SETTLE - 1)) r_state <= ST_CHECK;
          else r_settle_cnt <= r_settle_cnt + SET_W'(1);
        end
        ST_CHECK: begin
          if (r_round_cnt != '1) r_round_cnt <= r_round_cnt + RCNT_W'(1);
          if (io_bus.hp_result == RES_P1_WIN) begin
            r_state     <= ST_OVER;
            r_winner    <= WIN_P1;
            r_game_over <= 1'b1;
          end else if (io_bus.hp_result == RES_P2_WIN) begin
            r_state     <= ST_OVER;
            r_winner    <= WIN_P2;
            r_game_over <= 1'b1;
          end else begin
            r_state   <= ST_FETCH;
            r_db_req  <= 1'b1;
            r_db_addr <= (r_db_addr == ADDR_W'(NUM_Q - 1)) ? '0 : r_db_addr + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.db_req    = r_db_req;
  assign io_bus.db_addr   = r_db_addr;
  assign io_bus.q_show    = r_q_show;
  assign io_bus.q_level   = r_q.level;
  assign io_bus.q_num     = r_q.num;
  assign io_bus.hp_init   = r_hp_init;
  assign io_bus.hp_evt    = r_hp_evt;
  assign io_bus.game_over = r_game_over;
  assign io_bus.winner    = r_winner;
  assign io_bus.round_cnt = r_round_cnt;

endmodule
